// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   This block sits in the MEM stage. It turns a load or store request into a
//   handshake with a data memory whose latency varies. While the access is
//   outstanding it holds the pipeline in a stall. If the memory never answers,
//   it ends the instruction with a bubble and sets a sticky error flag.
//
// Parameters
//   TIMEOUT_CYC   largest number of ACCESS cycles spent waiting for mem_ack_i
//                 (legal range 1..31)
//
// Ports
//   clk_i         system clock; all state changes on the rising edge
//   rst_i         synchronous, active-high reset
//   MemRead_i     load request from the EX/MEM control bits
//   MemWrite_i    store request from the EX/MEM control bits
//   Addr_i        byte address
//   WrData_i      store data
//   mem_req_o     memory request, high in every ACCESS cycle
//   mem_we_o      1 = write, 0 = read; meaningful while mem_req_o is high
//   mem_addr_o    latched address
//   mem_wdata_o   latched store data
//   mem_ack_i     one-cycle completion pulse from memory
//   mem_rdata_i   read data, valid together with mem_ack_i
//   stall_o       freezes PC, IF/ID, ID/EX and EX/MEM, and holds MEM/WB
//                 (combinational)
//   RdData_o      load data for the MEM/WB stage
//   bubble_o      forces RegWrite=0 into MEM/WB for a timed-out access
//   err_o         sticky timeout flag, cleared only by reset
//   access_cnt_o  number of completed accesses, wraps modulo 2^16
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WrData_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] RdData_o,
  output logic        bubble_o,
  output logic        err_o,
  output logic [15:0] access_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } ctrlState_t;

  // The wait counter holds the value k-1 during ACCESS cycle k. Reaching
  // waitLast without an ack therefore means TIMEOUT_CYC cycles have passed.
  localparam logic [4:0] waitLast = 5'(TIMEOUT_CYC - 1);

  ctrlState_t stateReg, stateNext;
  logic [4:0] waitCntReg;
  logic       reqPending;
  logic       timeoutHit;

  assign reqPending = MemRead_i | MemWrite_i;
  assign timeoutHit = (waitCntReg == waitLast);

  // Next-state logic and the combinational stall.
  // DONE and ERR ignore the request inputs. During those cycles EX/MEM still
  // holds the instruction that just finished, so this stops it re-issuing.
  always_comb begin
    stateNext = stateReg;
    stall_o   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (reqPending) begin
          stall_o   = 1'b1;
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          stateNext = DONE;
        end else if (timeoutHit) begin
          stateNext = ERR;
        end
      end
      DONE:    stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // Reset releases the pipeline no matter what the request inputs show.
    if (rst_i) begin
      stall_o = 1'b0;
    end
  end

  // State and registered outputs. The outputs that belong to DONE or ERR are
  // loaded on the edge that enters that state. They are therefore visible
  // throughout the DONE or ERR cycle itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg     <= IDLE;
      waitCntReg   <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      RdData_o     <= '0;
      bubble_o     <= 1'b0;
      err_o        <= 1'b0;
      access_cnt_o <= '0;
    end else begin
      stateReg <= stateNext;
      case (stateReg)
        IDLE: begin
          if (reqPending) begin
            mem_req_o   <= 1'b1;
            // A store wins when both request bits are set.
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= Addr_i;
            mem_wdata_o <= WrData_i;
            waitCntReg  <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            mem_req_o    <= 1'b0;
            access_cnt_o <= access_cnt_o + 16'd1;
            if (!mem_we_o) begin
              RdData_o <= mem_rdata_i;
            end
          end else if (timeoutHit) begin
            mem_req_o <= 1'b0;
            bubble_o  <= 1'b1;
            RdData_o  <= '0;
            err_o     <= 1'b1;
          end else begin
            waitCntReg <= waitCntReg + 5'd1;
          end
        end
        ERR: begin
          bubble_o <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl.
// The driver decides each transaction's op, address, data and ack delay.
// From those it works out the complete expected outcome at issue time and
// queues it. Expected outcome: number of stall cycles, bus fields, read data,
// access count and error flag. The monitor is separate: it watches stall_o,
// and each time a stall run ends it pops one expectation and compares.
module tb_mem_access_ctrl;

  localparam int TO = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] Addr_i, WrData_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] RdData_o;
  logic        bubble_o, err_o;
  logic [15:0] access_cnt_o;

  mem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Addr_i(Addr_i), .WrData_i(WrData_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RdData_o(RdData_o), .bubble_o(bubble_o),
    .err_o(err_o), .access_cnt_o(access_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 = completed, 1 = timed out, 2 = abandoned by reset
  typedef struct {
    int          kind;
    int          nStall;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t expQ[$];

  int nChk  = 0;
  int nFail = 0;

  // Reference state, kept at transaction level.
  logic [31:0] mRd  = '0;
  logic [15:0] mCnt = '0;
  logic        mErr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int          stallCnt = 0;
  int          reqCnt   = 0;
  logic        seen     = 1'b0;
  logic        unstable = 1'b0;
  logic        obsWe;
  logic [31:0] obsAddr, obsWdata;
  int          txnNo    = 0;

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i === 1'b1) begin
      check("stall_in_reset", {31'd0, stall_o}, 32'd0);
    end
    if (stall_o === 1'b1) begin
      stallCnt++;
      if (mem_req_o === 1'b1) begin
        reqCnt++;
        if (!seen) begin
          seen     = 1'b1;
          obsWe    = mem_we_o;
          obsAddr  = mem_addr_o;
          obsWdata = mem_wdata_o;
        end else if (obsWe !== mem_we_o || obsAddr !== mem_addr_o || obsWdata !== mem_wdata_o) begin
          unstable = 1'b1;
        end
      end
    end else if (stallCnt > 0) begin
      if (expQ.size() == 0) begin
        nChk++;
        nFail++;
        $display("FAIL unexpected_completion: got stall run of %0d with no transaction pending", stallCnt);
      end else begin
        e = expQ.pop_front();
        txnNo++;
        check("stall_cycles", stallCnt, e.nStall);
        if (e.kind != 2) begin
          check("req_cycles", reqCnt, e.nStall - 1);
          check("bus_stable", {31'd0, unstable}, 32'd0);
          check("mem_we", {31'd0, obsWe}, {31'd0, e.we});
          check("mem_addr", obsAddr, e.addr);
          check("mem_wdata", obsWdata, e.wdata);
          check("req_dropped", {31'd0, mem_req_o}, 32'd0);
          check("bubble", {31'd0, bubble_o}, {31'd0, (e.kind == 1)});
          check("rd_data", RdData_o, e.rd);
          check("access_cnt", {16'd0, access_cnt_o}, {16'd0, e.cnt});
          check("err", {31'd0, err_o}, {31'd0, e.err});
        end
        $display("txn %0d kind=%0d stall=%0d we=%0b addr=%h rd=%h cnt=%0d err=%0b bubble=%0b",
                 txnNo, e.kind, stallCnt, obsWe, obsAddr, RdData_o, access_cnt_o, err_o, bubble_o);
      end
      stallCnt = 0;
      reqCnt   = 0;
      seen     = 1'b0;
      unstable = 1'b0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (30000) @(posedge clk_i);
    $display("FAIL watchdog: got no end of test, expected finish within 30000 cycles");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  // Every call starts and ends just after a rising edge.
  // d = 0 : no ack, so the access should time out.
  // d = k : ack is given in ACCESS cycle k.
  task automatic doTxn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int d);
    exp_t e;
    int   nAcc;
    nAcc     = (d == 0) ? TO : d;
    e.kind   = (d == 0) ? 1 : 0;
    e.nStall = 1 + nAcc;
    e.we     = wr;
    e.addr   = addr;
    e.wdata  = wdata;
    if (d == 0) begin
      mRd  = '0;
      mErr = 1'b1;
    end else begin
      mCnt = mCnt + 16'd1;
      if (!wr) mRd = rdata;
    end
    e.rd  = mRd;
    e.cnt = mCnt;
    e.err = mErr;
    expQ.push_back(e);
    MemRead_i  = rd;
    MemWrite_i = wr;
    Addr_i     = addr;
    WrData_i   = wdata;
    @(posedge clk_i); #1;
    for (int k = 1; k <= nAcc; k++) begin
      mem_ack_i   = (k == d);
      mem_rdata_i = (k == d) ? rdata : $urandom;
      @(posedge clk_i); #1;
    end
    mem_ack_i = 1'b0;
    // The DONE or ERR cycle: EX/MEM still holds the request.
    @(posedge clk_i); #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    Addr_i     = $urandom;
    WrData_i   = $urandom;
  endtask

  // Idle cycles, optionally with stray acks that the DUT must ignore.
  task automatic idle(input int n, input logic stray);
    for (int i = 0; i < n; i++) begin
      mem_ack_i   = stray & $urandom_range(0, 1);
      mem_rdata_i = $urandom;
      @(posedge clk_i); #1;
    end
    mem_ack_i = 1'b0;
  endtask

  initial begin
    exp_t r;
    int   op, d;
    rst_i       = 1'b1;
    MemRead_i   = 1'b1;
    MemWrite_i  = 1'b1;
    Addr_i      = 32'hFFFF_FFFF;
    WrData_i    = 32'hFFFF_FFFF;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_req", {31'd0, mem_req_o}, 32'd0);
    check("reset_we", {31'd0, mem_we_o}, 32'd0);
    check("reset_addr", mem_addr_o, 32'd0);
    check("reset_rd", RdData_o, 32'd0);
    check("reset_cnt", {16'd0, access_cnt_o}, 32'd0);
    check("reset_err", {31'd0, err_o}, 32'd0);
    check("reset_bubble", {31'd0, bubble_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i      = 1'b0;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    idle(2, 1'b1);

    // Directed cases
    doTxn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 1);   // fastest load
    idle(1, 1'b1);
    doTxn(1'b0, 1'b1, 32'h0000_0040, 32'h12345678, 32'hA5A5A5A5, 5); // store, 5 cycles
    idle(1, 1'b0);
    doTxn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0, 0);          // timeout
    idle(2, 1'b1);
    doTxn(1'b1, 1'b1, 32'h0000_0300, 32'hCAFEF00D, 32'h11112222, 2); // both bits set -> write
    doTxn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD0001, 1);   // back-to-back
    doTxn(1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'h0BAD0002, 1);
    doTxn(1'b1, 1'b0, 32'h0000_0408, 32'h0, 32'h0BAD0003, TO);  // ack in the last legal cycle

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      d  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      doTxn(op != 1, op != 0, $urandom, $urandom, $urandom, d);
      idle($urandom_range(0, 3), 1'b1);
    end

    // Reset asserted in ACCESS cycle 3, followed by a late ack
    r.kind = 2; r.nStall = 3; r.we = 1'b0; r.addr = '0; r.wdata = '0;
    r.rd = '0; r.cnt = '0; r.err = 1'b0;
    expQ.push_back(r);
    MemRead_i = 1'b1;
    Addr_i    = 32'h0000_0500;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    MemRead_i   = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h77777777;
    mRd  = '0;
    mCnt = '0;
    mErr = 1'b0;
    @(negedge clk_i);
    check("abort_req", {31'd0, mem_req_o}, 32'd0);
    check("abort_stall", {31'd0, stall_o}, 32'd0);
    check("abort_cnt", {16'd0, access_cnt_o}, 32'd0);
    check("abort_err", {31'd0, err_o}, 32'd0);
    check("abort_rd", RdData_o, 32'd0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    idle(2, 1'b0);
    @(negedge clk_i);
    check("late_ack_cnt", {16'd0, access_cnt_o}, 32'd0);
    check("late_ack_rd", RdData_o, 32'd0);
    @(posedge clk_i); #1;
    doTxn(1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'h600D600D, 3);
    idle(3, 1'b1);

    check("queue_drained", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
